// File: rtl/adder_serial_n.sv
// adder_serial_n: digit-serial N-bit add/subtract reusing one W-bit slice.
// Operands and results move over valid/ready; results are registered.
module adder_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         c_msb
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
    // carry into the top bit, recovered from the top sum bit
    assign c_msb = a[W-1] ^ b[W-1] ^ sum[W-1];
endmodule

module adder_serial_n #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow
);
    localparam int WS = (W < 1) ? 1 : W;
    localparam int K  = N / WS;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    if ((W < 1) || (W > N) || ((N % WS) != 0)) begin : g_bad_w
        $error("adder_serial_n: W must divide N and lie in 1..N");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          carry_q;
    logic [KW-1:0] k;
    logic [BW-1:0] base;
    logic          last;
    logic [W-1:0]  s_dig;
    logic          c_dig;
    logic          m_dig;

    assign base      = BW'(k) * BW'(W);
    assign last      = (k == KW'(K - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    adder_n #(.W(W)) u_slice (
        .a    (a_q[base +: W]),
        .b    (b_q[base +: W]),
        .c_in (carry_q),
        .sum  (s_dig),
        .c_out(c_dig),
        .c_msb(m_dig)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        // subtract is a + ~b + ~c_in
                        a_q     <= a;
                        b_q     <= b ^ {N{sub}};
                        carry_q <= c_in ^ sub;
                        k       <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    sum[base +: W] <= s_dig;
                    carry_q        <= c_dig;
                    k              <= k + 1'b1;
                    if (last) begin
                        c_out    <= c_dig;
                        overflow <= c_dig ^ m_dig;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_serial_n.sv
// tb_adder_serial_n: directed and random checks of adder_serial_n.
// Instances at W=1, W=8 (directed target) and W=32 share the inputs.
module tb_adder_serial_n;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             c_in = 1'b0;
    logic             sub = 1'b0;
    logic [31:0]      a = '0;
    logic [31:0]      b = '0;
    logic [2:0]       ir;
    logic [2:0]       ovd;
    logic [2:0]       rdy = 3'b111;
    logic [2:0]       co;
    logic [2:0]       of;
    logic [2:0][31:0] sm;
    int               passed = 0;
    int               total = 0;

    always #5 clk = ~clk;

    adder_serial_n #(.N(32), .W(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(ovd[0]), .out_ready(rdy[0]),
        .sum(sm[0]), .c_out(co[0]), .overflow(of[0])
    );

    adder_serial_n #(.N(32), .W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(ovd[1]), .out_ready(rdy[1]),
        .sum(sm[1]), .c_out(co[1]), .overflow(of[1])
    );

    adder_serial_n #(.N(32), .W(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .c_in(c_in), .sub(sub),
        .out_valid(ovd[2]), .out_ready(rdy[2]),
        .sum(sm[2]), .c_out(co[2]), .overflow(of[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] ai, input logic [31:0] bi,
                          input logic ci, input logic si,
                          output logic [31:0] s, output logic c,
                          output logic o, output int lat,
                          output bit leak);
        a = ai;
        b = bi;
        c_in = ci;
        sub = si;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        leak = 0;
        while (ovd[1] !== 1'b1 && lat < 100) begin
            if (ir[1] !== 1'b0) leak = 1;
            tick();
            lat++;
        end
        s = sm[1];
        c = co[1];
        o = of[1];
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        a = 32'd5;
        b = 32'd6;
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        total++;
        if (ovd[1] !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ovd[1]);
        else passed++;
        total++;
        if (ir[1] !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ir[1]);
        else passed++;
        total++;
        if (sm[1] !== 32'h0) $display("FAIL reset_sum got %h want 00000000", sm[1]);
        else passed++;
        total++;
        if ({co[1], of[1]} !== 2'b00)
            $display("FAIL reset_flags got c_out=%b ovf=%b want 0 0", co[1], of[1]);
        else passed++;
        tick();
        total++;
        if (ir[1] !== 1'b1) $display("FAIL reset_no_start in_ready got %b want 1", ir[1]);
        else passed++;
    endtask

    task automatic test_add();
        logic [31:0] s;
        logic        c, o;
        int          lat;
        bit          leak;
        run_op(32'hFFFFFFFB, 32'd14, 1'b1, 1'b0, s, c, o, lat, leak);
        total++;
        if (lat !== 4) $display("FAIL add_latency got %0d want 4", lat);
        else passed++;
        total++;
        if (leak) $display("FAIL add_in_ready_busy got 1 want 0");
        else passed++;
        total++;
        if (s !== 32'h0000000A) $display("FAIL add_sum got %h want 0000000a", s);
        else passed++;
        total++;
        if ({c, o} !== 2'b10) $display("FAIL add_flags got c_out=%b ovf=%b want 1 0", c, o);
        else passed++;
        total++;
        if ({ovd[1], ir[1]} !== 2'b01)
            $display("FAIL add_handoff got out_valid=%b in_ready=%b want 0 1", ovd[1], ir[1]);
        else passed++;
    endtask

    task automatic test_sub();
        logic [31:0] s;
        logic        c, o;
        int          lat;
        bit          leak;
        run_op(32'd5, 32'd7, 1'b0, 1'b1, s, c, o, lat, leak);
        total++;
        if (s !== 32'hFFFFFFFE) $display("FAIL sub1_sum got %h want fffffffe", s);
        else passed++;
        total++;
        if ({c, o} !== 2'b00) $display("FAIL sub1_flags got c_out=%b ovf=%b want 0 0", c, o);
        else passed++;
        run_op(32'd7, 32'd5, 1'b1, 1'b1, s, c, o, lat, leak);
        total++;
        if (s !== 32'h00000001) $display("FAIL sub2_sum got %h want 00000001", s);
        else passed++;
        total++;
        if ({c, o} !== 2'b10) $display("FAIL sub2_flags got c_out=%b ovf=%b want 1 0", c, o);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [31:0] s;
        logic        c, o;
        int          lat;
        bit          leak;
        run_op(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, s, c, o, lat, leak);
        total++;
        if (s !== 32'h80000000) $display("FAIL ovf1_sum got %h want 80000000", s);
        else passed++;
        total++;
        if ({c, o} !== 2'b01) $display("FAIL ovf1_flags got c_out=%b ovf=%b want 0 1", c, o);
        else passed++;
        run_op(32'h80000000, 32'd1, 1'b0, 1'b1, s, c, o, lat, leak);
        total++;
        if (s !== 32'h7FFFFFFF) $display("FAIL ovf2_sum got %h want 7fffffff", s);
        else passed++;
        total++;
        if ({c, o} !== 2'b11) $display("FAIL ovf2_flags got c_out=%b ovf=%b want 1 1", c, o);
        else passed++;
    endtask

    task automatic test_backpressure();
        int cyc;
        rdy[1] = 1'b0;
        a = 32'd1;
        b = 32'd2;
        c_in = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        while (ovd[1] !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        total++;
        if (ovd[1] !== 1'b1) $display("FAIL bp_reach_done got timeout want out_valid");
        else passed++;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = $urandom;
            b = $urandom;
            tick();
            total++;
            if ({ovd[1], ir[1], sm[1]} !== {1'b1, 1'b0, 32'd3})
                $display("FAIL bp_hold%0d got v=%b r=%b sum=%h want 1 0 00000003",
                         i, ovd[1], ir[1], sm[1]);
            else passed++;
        end
        in_valid = 1'b0;
        rdy[1] = 1'b1;
        tick();
        total++;
        if ({ovd[1], ir[1]} !== 2'b01)
            $display("FAIL bp_release got v=%b r=%b want 0 1", ovd[1], ir[1]);
        else passed++;
        tick();
        total++;
        if ({ir[1], sm[1]} !== {1'b1, 32'd3})
            $display("FAIL bp_retain got r=%b sum=%h want 1 00000003", ir[1], sm[1]);
        else passed++;
    endtask

    task automatic test_abort();
        bit seen;
        a = 32'd1;
        b = 32'd1;
        c_in = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({ir[1], ovd[1], sm[1]} !== {1'b1, 1'b0, 32'd0})
            $display("FAIL abort_state got r=%b v=%b sum=%h want 1 0 00000000",
                     ir[1], ovd[1], sm[1]);
        else passed++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ovd[1] !== 1'b0) seen = 1;
        end
        total++;
        if (seen) $display("FAIL abort_no_valid got out_valid=1 want 0");
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, bb;
        logic        rc, rs, rov;
        logic [32:0] rref;
        logic [2:0]  done, seen;
        int          cyc;
        rdy = 3'b000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            bb = rb ^ {32{rs}};
            rref = {1'b0, ra} + {1'b0, bb} + {32'd0, rc ^ rs};
            rov = (ra[31] == bb[31]) && (rref[31] != ra[31]);
            a = ra;
            b = rb;
            c_in = rc;
            sub = rs;
            rdy = 3'b000;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            done = 3'b000;
            seen = 3'b000;
            cyc = 0;
            while (done != 3'b111 && cyc < 300) begin
                for (int i = 0; i < 3; i++) begin
                    if (ovd[i] === 1'b1 && !done[i]) begin
                        if (!seen[i]) begin
                            seen[i] = 1'b1;
                            total++;
                            if ({co[i], of[i], sm[i]} !== {rref[32], rov, rref[31:0]})
                                $display("FAIL rand%0d_inst%0d got c=%b o=%b s=%h want c=%b o=%b s=%h",
                                         n, i, co[i], of[i], sm[i], rref[32], rov, rref[31:0]);
                            else passed++;
                        end
                        rdy[i] = ($urandom_range(0, 2) != 0);
                        if (rdy[i]) done[i] = 1'b1;
                    end
                end
                tick();
                cyc++;
            end
            total++;
            if (done !== 3'b111) $display("FAIL rand%0d_timeout got done=%b want 111", n, done);
            else passed++;
            rdy = 3'b000;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_backpressure();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/adder_serial_n.md
# adder_serial_n

Multi-cycle, digit-serial N-bit adder/subtractor that reuses one W-bit `adder_n` slice for N/W cycles, carrying between digits through a registered carry flop. It adds a subtract mode and a signed-overflow flag. Operands enter and results leave over valid/ready handshakes. It sits in the datapath where area matters more than latency, as the sequential successor to the combinational `adder_n`.

## Interface
- `N`, default 32: operand/result width in bits.
- `W`, default 8: digit width processed per cycle. Must divide N; otherwise an elaboration-time `$error`. Valid range 1..N.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  N  operand A.
- `b`  in  N  operand B.
- `c_in`  in  1  carry-in (add) or borrow-in (subtract).
- `sub`  in  1  0: a+b+c_in; 1: a−b−c_in.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  N  result, registered.
- `c_out`  out  1  carry out of bit N−1. In subtract mode, 1 means no borrow.
- `overflow`  out  1  signed two's-complement overflow of the result.

One clock; reset is synchronous and active-high.

## Operation
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid & in_ready`, latch into internal registers:
    - `a`;
    - `b ^ {N{sub}}`;
    - carry register ← `c_in ^ sub`.
  - Clear digit counter `k` to 0 and go to BUSY.
  - Subtract is therefore a + ~b + ~c_in, which equals a − b − c_in mod 2^N.
- **BUSY:**
  - Each cycle one W-bit slice adds digit k: bits [k·W+W−1 : k·W] of the latched operands plus the carry register.
  - Results written at the edge:
    - slice sum → sum bits for digit k;
    - slice carry → carry register;
    - `k` increments.
  - Track the carry into bit N−1. For W=1 this is the carry register entering the last digit; otherwise use the internal carry at bit W−1 of the last digit.
  - On the edge that processes digit N/W−1, go to DONE and set:
    - `c_out` = final carry;
    - `overflow` = carry into MSB XOR carry out of MSB.
- **DONE:**
  - `out_valid=1`.
  - `sum`, `c_out`, `overflow` hold stable until `out_valid & out_ready`; on that edge go to IDLE.
- **Outputs after handoff:** `sum`, `c_out`, `overflow` retain their last values in IDLE and BUSY. Only `out_valid` qualifies them.
- **Arithmetic:**
  - Result is mod 2^N.
  - `{c_out,sum}` equals `a + (b^{N{sub}}) + (c_in^sub)` computed at N+1 bits.
- **Ignored inputs:**
  - `in_valid` is ignored in BUSY and DONE; inputs are not queued.
  - `a`, `b`, `c_in`, `sub` are sampled only at the accept edge; later changes have no effect.

## Timing
- **Reset values** (on the `rst` edge, from any state):
  - state=IDLE, `k`=0, carry register=0;
  - `sum`=0, `c_out`=0, `overflow`=0;
  - `out_valid`=0, `in_ready`=1.
- **Reset precedence:** reset mid-BUSY or mid-DONE aborts the operation. No `out_valid` is produced for it.
- **Latency:** if operands are accepted at edge E0, `out_valid` rises after edge E0+N/W. With W=N, that is one BUSY cycle.
- **Throughput:** minimum N/W+2 cycles per operation (accept, N/W BUSY, DONE with `out_ready` already high).
- **Derived handshake signals:** `in_ready` and `out_valid` are pure functions of the state register, with no combinational path from `in_valid` or `out_ready`.
- **Backpressure:** with `out_ready=0`, DONE persists indefinitely with outputs frozen.
- **Simultaneous events:** `rst` has priority over both handshakes in the same cycle.

## Test plan
Benches use N=32, W=8 (latency 4) unless stated.

1. **Reset:** drive `rst` high for 2 cycles, with `in_valid=1` throughout, then release → `out_valid=0`, `in_ready=1`, `sum=0`, `c_out=0`, `overflow=0`, and no operation started.
2. **Add with carry wrap:** `a=32'hFFFFFFFB`, `b=32'd14`, `c_in=1`, `sub=0` → `sum=32'h0000000A`, `c_out=1`, `overflow=0`. `out_valid` rises exactly 4 edges after accept and `in_ready` is low throughout.
3. **Subtract with borrow:** `a=5`, `b=7`, `c_in=0`, `sub=1` → `sum=32'hFFFFFFFE`, `c_out=0`, `overflow=0`. Also `a=7`, `b=5`, `c_in=1`, `sub=1` → `sum=1`, `c_out=1`.
4. **Signed overflow:** `a=32'h7FFFFFFF`, `b=1`, `c_in=0`, `sub=0` → `sum=32'h80000000`, `overflow=1`, `c_out=0`. Also `a=32'h80000000`, `b=1`, `sub=1` → `sum=32'h7FFFFFFF`, `overflow=1`.
5. **Backpressure and mid-operation abort:**
   - Hold `out_ready=0` for 5 cycles in DONE while toggling `in_valid`, `a`, `b` → outputs frozen, `in_ready=0`, nothing accepted. Raise `out_ready` → IDLE next edge.
   - Separately, assert `rst` after 2 BUSY cycles → IDLE, `out_valid` never asserted.
6. **Randomised check:** 200 random `a`, `b`, `c_in`, `sub` with random `out_ready` stalls, each at W∈{1,8,32} → every result matches the N+1-bit reference model above, including `overflow`. Also elaborate W=5, N=32 and confirm it fails.
